// File: rtl/io_responder_pkg.sv
// Shared I/O-space register map for the CPU byte port: register selects and
// status-bit positions, also used by riscv_top.
package io_responder_pkg;

    localparam logic [2:0] IO_REG_DATA   = 3'd0;
    localparam logic [2:0] IO_REG_STATUS = 3'd1;
    localparam logic [2:0] IO_REG_CNT0   = 3'd2;
    localparam logic [2:0] IO_REG_CNT1   = 3'd3;
    localparam logic [2:0] IO_REG_CNT2   = 3'd4;
    localparam logic [2:0] IO_REG_CNT3   = 3'd5;
    // The halt/exit register shares its select with counter byte 2 (store vs load).
    localparam logic [2:0] IO_REG_HALT   = IO_REG_CNT2;

    localparam int STAT_TX_FULL     = 0;
    localparam int STAT_RX_NONEMPTY = 1;
    localparam int STAT_OVERFLOW    = 2;

    function automatic logic [7:0] status_byte(input logic overflow,
                                               input logic rx_nonempty,
                                               input logic tx_full);
        logic [7:0] s;
        s                   = '0;
        s[STAT_OVERFLOW]    = overflow;
        s[STAT_RX_NONEMPTY] = rx_nonempty;
        s[STAT_TX_FULL]     = tx_full;
        return s;
    endfunction

endpackage

// File: rtl/io_responder_if.sv
// CPU byte-port request/response plus host character stream and halt status.
interface io_responder_if;
    logic       rdy_in;
    logic       en_in;
    logic [2:0] a_in;
    logic       wr_in;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic [7:0] tx_data_out;
    logic       tx_valid_out;
    logic       tx_ready_in;
    logic [7:0] rx_data_in;
    logic       rx_valid_in;
    logic       rx_ready_out;
    logic       halt_out;
    logic [7:0] exit_code_out;

    modport slave (
        input  rdy_in, en_in, a_in, wr_in, d_in, tx_ready_in, rx_data_in, rx_valid_in,
        output d_out, tx_data_out, tx_valid_out, rx_ready_out, halt_out, exit_code_out
    );

    modport master (
        output rdy_in, en_in, a_in, wr_in, d_in, tx_ready_in, rx_data_in, rx_valid_in,
        input  d_out, tx_data_out, tx_valid_out, rx_ready_out, halt_out, exit_code_out
    );
endinterface

// File: rtl/io_responder_byte_fifo.sv
// First-word-fall-through FIFO; pointers carry a wrap bit so full and empty
// are distinguished without a separate count.
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    // Flags are pre-edge: a full FIFO refuses a push even when popped this cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are
    // valid, so the array stays a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/io_responder.sv
// I/O-space responder: CPU loads/stores with 1-cycle read latency, TX/RX
// character FIFOs to the host, cycle counter with snapshot, halt/exit register.
module io_responder
    import io_responder_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input logic            clk_in,
    input logic            rst_n_in,
    io_responder_if.slave  bus
);
    logic                 load, store;
    logic                 tx_push, tx_full, tx_empty;
    logic                 rx_pop, rx_full, rx_empty;
    logic [7:0]           tx_dout, rx_dout, rd_data;
    logic [7:0]           d_q, exit_code_q;
    logic                 overflow, halt_q;
    logic [CNT_WIDTH-1:0] cnt;
    logic [23:0]          shadow;

    assign load    = bus.en_in & bus.rdy_in & ~bus.wr_in;
    assign store   = bus.en_in & bus.rdy_in &  bus.wr_in;
    assign tx_push = store && (bus.a_in == IO_REG_DATA);
    assign rx_pop  = load  && (bus.a_in == IO_REG_DATA);

    byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push  (tx_push),
        .din   (bus.d_in),
        .pop   (bus.tx_ready_in),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push  (bus.rx_valid_in),
        .din   (bus.rx_data_in),
        .pop   (rx_pop),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // NOTE: rd_data gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_data = '0;
        unique case (bus.a_in)
            IO_REG_DATA:   rd_data = rx_empty ? 8'h00 : rx_dout;
            IO_REG_STATUS: rd_data = status_byte(overflow, ~rx_empty, tx_full);
            IO_REG_CNT0:   rd_data = cnt[7:0];
            IO_REG_CNT1:   rd_data = shadow[7:0];
            IO_REG_CNT2:   rd_data = shadow[15:8];
            IO_REG_CNT3:   rd_data = shadow[23:16];
            default:       rd_data = '0;
        endcase
    end

    // NOTE: all state updates use <= so every flop sees pre-edge values; the
    // snapshot below captures the counter before this edge's increment.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            d_q         <= '0;
            cnt         <= '0;
            shadow      <= '0;
            overflow    <= 1'b0;
            halt_q      <= 1'b0;
            exit_code_q <= '0;
        end else begin
            if (bus.rdy_in) cnt <= cnt + CNT_WIDTH'(1);
            if (load) d_q <= rd_data;
            if (load && bus.a_in == IO_REG_CNT0) shadow <= cnt[31:8];
            if (tx_push && tx_full) begin
                overflow <= 1'b1;
            end else if (store && bus.a_in == IO_REG_STATUS) begin
                overflow <= 1'b0;
            end
            if (store && bus.a_in == IO_REG_HALT) begin
                halt_q      <= 1'b1;
                exit_code_q <= bus.d_in;
            end
        end
    end

    assign bus.d_out         = d_q;
    assign bus.tx_data_out   = tx_dout;
    assign bus.tx_valid_out  = ~tx_empty;
    assign bus.rx_ready_out  = ~rx_full;
    assign bus.halt_out      = halt_q;
    assign bus.exit_code_out = exit_code_q;

endmodule

// File: tb/tb_io_responder.sv
// Scoreboard bench for io_responder: a queue-based reference model predicts
// load data and stream state; a negedge monitor compares against the DUT.
module tb_io_responder;
    import io_responder_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    io_responder_if bus_if ();

    io_responder #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFOs as queues, counter as a plain integer.
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    bit          m_ovf  = 0;
    bit          m_halt = 0;
    logic [7:0]  m_code = '0;
    logic [31:0] m_cnt  = '0;
    logic [31:0] m_snap = '0;

    always @(posedge clk or negedge rst_n) begin : model
        bit         req, tx_had, tx_full, rx_had, rx_full;
        logic [7:0] ld;
        if (!rst_n) begin
            tx_q.delete();
            rx_q.delete();
            m_ovf  = 0;
            m_halt = 0;
            m_code = '0;
            m_cnt  = '0;
            m_snap = '0;
        end else begin
            req     = bus_if.en_in && bus_if.rdy_in;
            tx_had  = tx_q.size() != 0;
            tx_full = tx_q.size() == DEPTH;
            rx_had  = rx_q.size() != 0;
            rx_full = rx_q.size() == DEPTH;
            if (bus_if.tx_ready_in && tx_had) void'(tx_q.pop_front());
            if (req && !bus_if.wr_in) begin
                case (bus_if.a_in)
                    3'd0:    ld = rx_had ? rx_q.pop_front() : 8'h00;
                    3'd1:    ld = {5'b0, m_ovf, rx_had, tx_full};
                    3'd2:    begin ld = m_cnt[7:0]; m_snap = m_cnt; end
                    3'd3:    ld = m_snap[15:8];
                    3'd4:    ld = m_snap[23:16];
                    3'd5:    ld = m_snap[31:24];
                    default: ld = 8'h00;
                endcase
                exp_q.push_back(ld);
            end
            if (req && bus_if.wr_in) begin
                case (bus_if.a_in)
                    3'd0:    if (tx_full) m_ovf = 1; else tx_q.push_back(bus_if.d_in);
                    3'd1:    m_ovf = 0;
                    3'd4:    begin m_halt = 1; m_code = bus_if.d_in; end
                    default: ;
                endcase
            end
            if (bus_if.rx_valid_in && !rx_full) rx_q.push_back(bus_if.rx_data_in);
            if (bus_if.rdy_in) m_cnt = m_cnt + 32'd1;
        end
    end

    // Monitor: d_out holds the most recent predicted load result.
    logic [7:0] last_exp = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            last_exp = '0;
        end else begin
            if (exp_q.size() != 0) last_exp = exp_q.pop_front();
            check("d_out", 32'(bus_if.d_out), 32'(last_exp));
            check("tx_valid", 32'(bus_if.tx_valid_out), 32'(tx_q.size() != 0));
            if (tx_q.size() != 0) check("tx_data", 32'(bus_if.tx_data_out), 32'(tx_q[0]));
            check("rx_ready", 32'(bus_if.rx_ready_out), 32'(rx_q.size() != DEPTH));
            check("halt", 32'(bus_if.halt_out), 32'(m_halt));
            check("exit_code", 32'(bus_if.exit_code_out), 32'(m_code));
        end
    end

    // Called at a negedge: present one bus cycle, return at the next negedge.
    task automatic drive(input bit en, input bit wr, input logic [2:0] a, input logic [7:0] d);
        bus_if.en_in = en;
        bus_if.wr_in = wr;
        bus_if.a_in  = a;
        bus_if.d_in  = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'd0, 8'h00);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_d_out"},     32'(bus_if.d_out),         32'h00);
        check({tag, "_tx_valid"},  32'(bus_if.tx_valid_out),  32'h0);
        check({tag, "_rx_ready"},  32'(bus_if.rx_ready_out),  32'h1);
        check({tag, "_halt"},      32'(bus_if.halt_out),      32'h0);
        check({tag, "_exit_code"}, 32'(bus_if.exit_code_out), 32'h00);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bus_if.rdy_in      = 1'b1;
        bus_if.en_in       = 1'b0;
        bus_if.wr_in       = 1'b0;
        bus_if.a_in        = 3'd0;
        bus_if.d_in        = 8'h00;
        bus_if.tx_ready_in = 1'b0;
        bus_if.rx_data_in  = 8'h00;
        bus_if.rx_valid_in = 1'b0;

        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Two TX bytes stream out one per cycle, then valid drops.
        bus_if.tx_ready_in = 1'b1;
        drive(1'b1, 1'b1, IO_REG_DATA, 8'h41);
        check("tx_first", 32'(bus_if.tx_data_out), 32'h41);
        drive(1'b1, 1'b1, IO_REG_DATA, 8'h42);
        check("tx_second", 32'(bus_if.tx_data_out), 32'h42);
        idle(1);
        check("tx_drained", 32'(bus_if.tx_valid_out), 32'h0);

        // 17 stores into a stalled TX: 16 held, overflow set, then cleared.
        bus_if.tx_ready_in = 1'b0;
        for (int i = 0; i < 17; i++) drive(1'b1, 1'b1, IO_REG_DATA, 8'(i + 8'h60));
        drive(1'b1, 1'b0, IO_REG_STATUS, 8'h00);
        check("status_full_ovf", 32'(bus_if.d_out), 32'h05);
        drive(1'b1, 1'b1, IO_REG_STATUS, 8'h00);
        drive(1'b1, 1'b0, IO_REG_STATUS, 8'h00);
        check("status_ovf_cleared", 32'(bus_if.d_out), 32'h01);
        bus_if.tx_ready_in = 1'b1;
        idle(20);

        // Host pushes two bytes; three CPU reads return them then zero.
        bus_if.rx_valid_in = 1'b1;
        bus_if.rx_data_in  = 8'h10;
        idle(1);
        bus_if.rx_data_in  = 8'h20;
        idle(1);
        bus_if.rx_valid_in = 1'b0;
        drive(1'b1, 1'b0, IO_REG_DATA, 8'h00);
        check("rx_read0", 32'(bus_if.d_out), 32'h10);
        drive(1'b1, 1'b0, IO_REG_DATA, 8'h00);
        check("rx_read1", 32'(bus_if.d_out), 32'h20);
        drive(1'b1, 1'b0, IO_REG_DATA, 8'h00);
        check("rx_read_empty", 32'(bus_if.d_out), 32'h00);
        idle(1);

        // Counter snapshot, then a 50-cycle pause with ignored bus requests.
        idle(300);
        for (int r = 2; r <= 5; r++) drive(1'b1, 1'b0, 3'(r), 8'h00);
        bus_if.rdy_in = 1'b0;
        drive(1'b1, 1'b0, IO_REG_CNT0, 8'h00);
        drive(1'b1, 1'b1, IO_REG_HALT, 8'h99);
        idle(48);
        bus_if.rdy_in = 1'b1;
        for (int r = 2; r <= 5; r++) drive(1'b1, 1'b0, 3'(r), 8'h00);
        idle(1);

        // Halt, then async reset mid-cycle with live state everywhere.
        drive(1'b1, 1'b1, IO_REG_HALT, 8'h2A);
        check("halt_set", 32'(bus_if.halt_out), 32'h1);
        check("halt_code", 32'(bus_if.exit_code_out), 32'h2A);
        bus_if.tx_ready_in = 1'b0;
        drive(1'b1, 1'b1, IO_REG_DATA, 8'h77);
        drive(1'b1, 1'b0, IO_REG_CNT0, 8'h00);
        bus_if.rx_valid_in = 1'b1;
        bus_if.rx_data_in  = 8'h55;
        idle(1);
        bus_if.rx_valid_in = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Fill RX, then host push and CPU pop collide on the full FIFO.
        bus_if.rx_valid_in = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus_if.rx_data_in = 8'(i + 1);
            idle(1);
        end
        check("rx_full_not_ready", 32'(bus_if.rx_ready_out), 32'h0);
        bus_if.rx_data_in = 8'hEE;
        drive(1'b1, 1'b0, IO_REG_DATA, 8'h00);
        check("rx_full_pop_data", 32'(bus_if.d_out), 32'h01);
        check("rx_ready_after_pop", 32'(bus_if.rx_ready_out), 32'h1);
        bus_if.rx_valid_in = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) drive(1'b1, 1'b0, IO_REG_DATA, 8'h00);
        check("rx_last_kept", 32'(bus_if.d_out), 32'h10);
        drive(1'b1, 1'b0, IO_REG_DATA, 8'h00);
        check("rx_push_rejected", 32'(bus_if.d_out), 32'h00);

        // Randomized traffic on both sides.
        for (int i = 0; i < 600; i++) begin
            bus_if.rdy_in      = ($urandom_range(7) != 0);
            bus_if.tx_ready_in = $urandom_range(1);
            bus_if.rx_valid_in = $urandom_range(1);
            bus_if.rx_data_in  = 8'($urandom);
            drive(1'($urandom_range(1)), 1'($urandom_range(1)),
                  3'($urandom_range(7)), 8'($urandom));
        end
        bus_if.rdy_in      = 1'b1;
        bus_if.rx_valid_in = 1'b0;
        bus_if.tx_ready_in = 1'b1;
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
